// File: rtl/main_core_if.sv
// Instruction/result bundle between the board sequencer and main_core.
interface main_core_if;
  logic [16:0] state;
  logic [15:0] ALU_result;
  logic [4:0]  flags;
  logic [7:0]  led;
  logic [3:0]  ledState;

  modport master (output state, input ALU_result, flags, led, ledState);
  modport slave  (input state, output ALU_result, flags, led, ledState);
endinterface

// File: rtl/main_core.sv
// Single-cycle 16x16 register file + ALU with a 4-digit multiplexed seven-segment driver.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits 3..1).
module main_core #(
  parameter int REFRESH_BITS = 16
) (
  input  logic       clk,
  input  logic       reset,
  main_core_if.slave bus
);

  logic        imm;
  logic [3:0]  op, ra, rb, rd;
  logic [15:0] regs [16];
  logic [15:0] a, b, alu;
  logic [16:0] sum, diff;
  logic        wr_en, ovf_add, ovf_sub;
  logic [4:0]  flags_q;

  assign {imm, op, ra, rb, rd} = bus.state;
  assign a = regs[ra];
  assign b = imm ? {12'd0, rb} : regs[rb];

  assign sum     = {1'b0, a} + {1'b0, b};
  assign diff    = {1'b0, a} - {1'b0, b};
  assign ovf_add = (a[15] == b[15]) && (sum[15]  != a[15]);
  assign ovf_sub = (a[15] != b[15]) && (diff[15] != a[15]);

  always_comb begin
    alu   = '0;
    wr_en = 1'b1;
    case (op)
      4'h0: alu = a & b;
      4'h1: alu = a | b;
      4'h2: alu = sum[15:0];
      4'h3: alu = diff[15:0];
      4'h4: alu = a ^ b;
      4'h5: alu = ~a;
      4'h6: alu = a << b[3:0];
      4'h7: alu = a >> b[3:0];
      4'h8: alu = $signed(a) >>> b[3:0];
      4'h9: begin alu = diff[15:0]; wr_en = 1'b0; end
      4'hA: alu = b;
      default: wr_en = 1'b0;
    endcase
  end

  assign bus.ALU_result = alu;
  assign bus.flags      = flags_q;

  // flags_q = {C, L, F, Z, N}
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
      flags_q <= '0;
    end else begin
      if (wr_en) regs[rd] <= alu;
      case (op)
        4'h2: begin flags_q[4] <= sum[16];  flags_q[2] <= ovf_add; end
        4'h3: begin flags_q[4] <= diff[16]; flags_q[2] <= ovf_sub; end
        4'h9: begin
          flags_q[1] <= (diff[15:0] == 16'd0);
          flags_q[3] <= diff[16];
          // signed less-than: sign of the difference corrected for overflow
          flags_q[0] <= diff[15] ^ ovf_sub;
        end
        default: ;
      endcase
    end
  end

  logic [REFRESH_BITS-1:0] refresh_cnt;
  logic [1:0]              digit_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
      if (&refresh_cnt) digit_idx <= digit_idx + 2'd1;
    end
  end

  logic [3:0] nibble;
  logic [7:0] glyph;
  logic       blank;

  always_comb begin
    case (digit_idx)
      2'd0:    nibble = alu[3:0];
      2'd1:    nibble = alu[7:4];
      2'd2:    nibble = alu[11:8];
      default: nibble = alu[15:12];
    endcase
  end

  always_comb begin
    case (nibble)
      4'h0: glyph = 8'hC0; 4'h1: glyph = 8'hF9; 4'h2: glyph = 8'hA4; 4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99; 4'h5: glyph = 8'h92; 4'h6: glyph = 8'h82; 4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80; 4'h9: glyph = 8'h90; 4'hA: glyph = 8'h88; 4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6; 4'hD: glyph = 8'hA1; 4'hE: glyph = 8'h86; default: glyph = 8'h8E;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blank when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    case (digit_idx)
      2'd1:    blank = (alu[15:4]  == 12'd0);
      2'd2:    blank = (alu[15:8]  == 8'd0);
      2'd3:    blank = (alu[15:12] == 4'd0);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  assign bus.led      = blank ? 8'hFF : glyph;
  assign bus.ledState = ~(4'b0001 << digit_idx);

endmodule

// File: tb/tb_main_core.sv
// Randomized scoreboard bench for main_core against an arithmetic reference model.
module tb_main_core;
  localparam int RB = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  main_core_if bus ();

  main_core #(.REFRESH_BITS(RB)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct { logic [15:0] alu; logic [4:0] flg; } rec_t;
  rec_t q[$];

  int n_tests = 0, n_fail = 0;
  int edges = 0;

  logic [15:0] mregs [16];
  logic [4:0]  mflg;   // {C, L, F, Z, N}
  logic [7:0]  glyphs [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  always @(posedge clk or negedge reset)
    if (!reset) edges <= 0; else edges <= edges + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_led(input logic [15:0] v, input int d);
    logic [7:0] g;
    g = glyphs[(v >> (4 * d)) & 16'hF];
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && (v >> (4 * d)) == 16'd0) g = 8'hFF;
`endif
    return g;
  endfunction

  // Reference: operands and results as plain integers.
  task automatic model(input logic [16:0] ins, output logic [15:0] r, output bit wr,
                       output logic [4:0] nf);
    logic [3:0] op, ra, rb;
    logic [15:0] a, b;
    int ua, ub, sa, sb, s;
    op = ins[15:12]; ra = ins[11:8]; rb = ins[7:4];
    a = mregs[ra];
    b = ins[16] ? {12'd0, rb} : mregs[rb];
    ua = int'(a); ub = int'(b); sa = int'($signed(a)); sb = int'($signed(b));
    nf = mflg; r = 16'd0;
    wr = (op <= 4'd10) && (op != 4'd9);
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: begin r = 16'(ua + ub); nf[4] = (ua + ub) > 65535;
                  s = sa + sb; nf[2] = (s > 32767) || (s < -32768); end
      4'd3: begin r = 16'(ua - ub); nf[4] = ua < ub;
                  s = sa - sb; nf[2] = (s > 32767) || (s < -32768); end
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: r = 16'(ua * (1 << ub[3:0]));
      4'd7: r = 16'(ua / (1 << ub[3:0]));
      4'd8: r = 16'(sa >>> ub[3:0]);
      4'd9: begin r = 16'(ua - ub); nf[1] = (ua == ub); nf[3] = (ua < ub); nf[0] = (sa < sb); end
      4'd10: r = b;
      default: r = 16'd0;
    endcase
  endtask

  // Called just after a rising edge: present ins, queue expectation, commit at next edge.
  task automatic step(input logic [16:0] ins);
    logic [15:0] r; bit wr; logic [4:0] nf;
    bus.state = ins;
    model(ins, r, wr, nf);
    q.push_back('{alu: r, flg: mflg});
    @(posedge clk);
    if (wr) mregs[ins[3:0]] = r;
    mflg = nf;
    #1;
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) step({1'b0, 4'hA, 4'h0, 4'(i), 4'(i)});
  endtask

  task automatic fib_pass();
    for (int k = 0; k < 16; k++) step({1'b0, 4'h2, 4'(k - 1), 4'(k - 2), 4'(k)});
  endtask

  always @(negedge clk) begin
    rec_t e;
    int d;
    if (q.size() > 0) begin
      e = q.pop_front();
      d = (edges >> RB) & 3;
      chk("alu", 32'(bus.ALU_result), 32'(e.alu));
      chk("flags", 32'(bus.flags), 32'(e.flg));
      chk("ledState", 32'(bus.ledState), 32'(~(4'b0001 << d) & 4'hF));
      chk("led", 32'(bus.led), 32'(exp_led(e.alu, d)));
    end
  end

  initial begin
    logic [15:0] r; bit wr; logic [4:0] nf;
    logic [16:0] ins;
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    mflg = '0;
    bus.state = 17'h12E1F;
    #2;
    chk("rst_flags", 32'(bus.flags), 32'h0);
    chk("rst_ledState", 32'(bus.ledState), 32'hE);
    chk("rst_alu", 32'(bus.ALU_result), 32'h1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    step(17'h12E1F);
    fib_pass();
    // hold 16'h063D on the display for a full scan
    repeat (20) step({1'b0, 4'hA, 4'hF, 4'hF, 4'hF});
    fib_pass();
    read_all();

    step({1'b1, 4'hA, 4'h0, 4'h5, 4'h1});
    step({1'b1, 4'hA, 4'h0, 4'h9, 4'h2});
    step({1'b0, 4'h9, 4'h1, 4'h2, 4'h0});
    step({1'b0, 4'h9, 4'h2, 4'h2, 4'h1});
    step({1'b0, 4'hB, 4'h1, 4'h2, 4'h3});
    read_all();

    repeat (300) begin
      ins = 17'($urandom);
      if ($urandom_range(0, 3) == 0) ins[15:12] = 4'($urandom_range(11, 15));
      if ($urandom_range(0, 3) == 0) ins[15:12] = 4'h9;
      step(ins);
    end
    read_all();

    // Asynchronous reset between edges with a pending write
    ins = {1'b1, 4'h2, 4'h3, 4'h7, 4'h3};
    bus.state = ins;
    model(ins, r, wr, nf);
    q.push_back('{alu: r, flg: mflg});
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    mflg = '0;
    model(ins, r, wr, nf);
    chk("mid_rst_ledState", 32'(bus.ledState), 32'hE);
    chk("mid_rst_flags", 32'(bus.flags), 32'h0);
    chk("mid_rst_alu", 32'(bus.ALU_result), 32'(r));
    chk("mid_rst_led", 32'(bus.led), 32'(glyphs[r[3:0]]));
    @(posedge clk);
    #1 reset = 1'b1;
    read_all();

    repeat (60) step(17'($urandom));
    read_all();

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) chk("drain_timeout", 32'(q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/main_core.md
# main_core

Single-cycle register-file + ALU datapath with a 4-digit multiplexed seven-segment driver on the same clock. Each cycle it executes one 17-bit instruction word supplied on `state`: it reads two operands, computes `ALU_result` combinationally and writes the result back on the next rising edge. `ALU_result` also drives the board LEDs as four hex digits. It sits under the board top level, which sequences instruction words such as the Fibonacci program.

## Interface
- `REFRESH_BITS`, default 16: each digit is lit for 2^REFRESH_BITS clocks.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `state` in 17: instruction `{imm[16], op[15:12], ra[11:8], rb[7:4], rd[3:0]}`.
- `ALU_result` out 16: combinational ALU result for the current `state`.
- `flags` out 5: registered `{C, L, F, Z, N}`.
- `led` out 8: active-low segments `{dp,g,f,e,d,c,b,a}`.
- `ledState` out 4: active-low one-hot digit anodes; bit0 is the rightmost digit.

## Operation
- Register file: 16 × 16-bit registers.
- Operand A = R[ra].
- Operand B = R[rb] when imm=0; when imm=1, B = zero-extended `rb` field (0..15).
- Opcodes:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 SUB (A−B); 0100 XOR; 0101 NOT A.
  - 0110 LSH: A << B[3:0]. 0111 RSH: logical, A >> B[3:0]. 1000 ASHR: arithmetic, by B[3:0].
  - 1001 CMP: result = A−B, no write-back.
  - 1010 MOV: result = B.
  - 1011–1111: result 0, no write-back, flags held.
- Write-back: on rising `clk`, R[rd] <= ALU_result for every opcode except CMP and the reserved codes. Results are 16-bit and wrap modulo 2^16.
- Flag updates:
  - ADD sets C = carry out and F = signed overflow.
  - SUB sets C = borrow (A<B unsigned) and F = signed overflow.
  - CMP sets Z = (A==B), L = (A<B unsigned), N = (A<B signed).
  - All other flags hold.
- Display:
  - A 2-bit digit index advances every 2^REFRESH_BITS clocks and wraps 3→0.
  - Digit i shows nibble `ALU_result[4i+3:4i]`; `ledState` = ~(1<<i); dp is always off.
  - Glyphs, hex 0–F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
  - Segments decode combinationally from the live `ALU_result`.

## Timing
- Reset is asynchronous and active-low: all registers, flags, refresh counter and digit index go to 0 immediately.
  - During reset `ALU_result` still follows `state` over the zeroed registers.
  - During reset `ledState` = 4'b1110 and `led` = glyph of `ALU_result[3:0]`.
  - On release, the first write occurs on the first rising edge with `reset`=1.
- Latency: `ALU_result` is valid combinationally in the same cycle as `state`; the register and flag update is visible one edge later.
- Read-after-write: reading rd in the next instruction returns the new value; there are no hazards and no bypass is needed.
- rd equal to ra or rb: operands are sampled before the write, so R[rd] <= f(old values).
- Reset asserted mid-operation discards the pending write.
- Digit switch: exactly one anode is low at any time, and it changes on the clock edge where the refresh counter wraps.

## Configuration
- `LEADING_ZERO_BLANK_EN`
  - Defined: digits 3..1 that are zero and above the most significant non-zero digit are blanked (`led`=8'hFF, anode still scanned). Digit 0 is never blanked.
  - Undefined: all four digits are always shown, including leading zeros.

## Test plan
- Reset, then `state`=17'h12E1F (R15 = R14 + imm 1) -> `ALU_result`=1 before the edge, R15=1 after; `flags`=0.
- Fibonacci: apply 0x02FE0, 0x020F1, 0x02102, … 0x02EDF (Rk = R(k−1) + R(k−2)) -> `ALU_result` = 1, 2, 3, 5, 8 … 987, 1597 (16'h063D).
- Wrap: second pass of the same sequence -> R6 = 46368 with C=0, then R7 = 16'h2511 (75025 mod 2^16) with C=1.
- CMP: R1=5, R2=9, CMP ra=1 rb=2 -> L=1, N=1, Z=0, no register changes.
- CMP equal: CMP ra=2 rb=2 -> Z=1, L=0, N=0, no register changes.
- Display with REFRESH_BITS=2 and `ALU_result`=16'h063D -> (`ledState`, `led`) cycles (1110,A1), (1101,B0), (1011,82), (0111,C0) every 4 clocks.
  - With `LEADING_ZERO_BLANK_EN` defined, digit 3 shows FF.
- Mid-run reset: assert `reset`=0 asynchronously between edges -> all registers read 0, `ledState`=1110 immediately.
